// File: rtl/seq_divider_pkg.sv
// Shared divider definitions: FSM state encoding,
// iteration count and the divide-by-zero quotient.
package seq_divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } div_state_e;

  localparam int          DIV_ITER      = 32;
  localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;

endpackage

// File: rtl/seq_divider_div_step.sv
// div_step: one combinational restoring-division step.
// rem_i/quo_i/dvs_i in, rem_o/quo_o = state after one step.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0] sh;
  logic [WIDTH:0] diff;

  always_comb begin
    // Extra top bit keeps the shifted remainder exact.
    sh   = {rem_i, quo_i[WIDTH-1]};
    diff = sh - {1'b0, dvs_i};
    if (!diff[WIDTH]) begin
      rem_o = diff[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b1};
    end else begin
      rem_o = sh[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/seq_divider.sv
// seq_divider: 32-step iterative DIV/DIVU for the EX stage.
// start/flush/is_signed/dividend/divisor in; busy/done/quotient/remainder out.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             flush,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  div_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] raw_q;
  logic             qneg_q;
  logic             rneg_q;
  logic             sgn_q;
  logic             dbz_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] quot_q;
  logic [WIDTH-1:0] remd_q;

  logic [WIDTH-1:0] a_mag_d;
  logic [WIDTH-1:0] b_mag_d;
  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] quo_d;
  logic [WIDTH-1:0] q_fix_d;
  logic [WIDTH-1:0] r_fix_d;
  logic             last_d;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dvs_i (dvs_q),
    .rem_o (rem_d),
    .quo_o (quo_d)
  );

  always_comb begin
    // |0x80000000| stays 0x80000000, read as unsigned.
    a_mag_d = (is_signed && dividend[WIDTH-1])
            ? -dividend : dividend;
    b_mag_d = (is_signed && divisor[WIDTH-1])
            ? -divisor : divisor;
    last_d  = (cnt_q == CNT_W'(DIV_ITER - 1));
    q_fix_d = (sgn_q && qneg_q) ? -quo_q : quo_q;
    r_fix_d = (sgn_q && rneg_q) ? -rem_q : rem_q;
    if (dbz_q) begin
      q_fix_d = WIDTH'(DIV_BY_ZERO_Q);
      r_fix_d = raw_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      raw_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      sgn_q   <= 1'b0;
      dbz_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= '0;
      remd_q  <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start && !flush) begin
            quo_q   <= a_mag_d;
            dvs_q   <= b_mag_d;
            rem_q   <= '0;
            cnt_q   <= '0;
            raw_q   <= dividend;
            sgn_q   <= is_signed;
            qneg_q  <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            rneg_q  <= dividend[WIDTH-1];
            dbz_q   <= (divisor == '0);
            busy_q  <= 1'b1;
            state_q <= CALC;
          end
        end
        CALC: begin
          if (flush) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q + CNT_W'(1);
            if (last_d) state_q <= FIX;
          end
        end
        FIX: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
          if (!flush) begin
            quot_q <= q_fix_d;
            remd_q <= r_fix_d;
            done_q <= 1'b1;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quot_q;
  assign remainder = remd_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider:
// latency, signed/unsigned results, div-by-zero, flush, reset, back-to-back.
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        flush;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;

  int n_cmp = 0;
  int n_err = 0;

  seq_divider dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .flush     (flush),
    .is_signed (is_signed),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Present an operation in the current cycle (cycle 0);
  // returns in cycle 1.
  task automatic launch(input logic sg,
                        input logic [31:0] a,
                        input logic [31:0] b);
    is_signed = sg;
    dividend  = a;
    divisor   = b;
    start     = 1'b1;
    cyc();
    start     = 1'b0;
  endtask

  // Called in cycle 1: busy must hold through 33, done only in 34.
  task automatic finish_op(input string tag,
                           input logic [31:0] eq,
                           input logic [31:0] er);
    logic ok;
    ok = 1'b1;
    for (int c = 1; c <= 33; c++) begin
      if (!(busy === 1'b1 && done === 1'b0)) ok = 1'b0;
      cyc();
    end
    chk({tag, "_busy1to33"}, {31'b0, ok}, 32'd1);
    chk({tag, "_done34"}, {30'b0, done, busy}, 32'd2);
    chk({tag, "_quo"}, quotient, eq);
    chk({tag, "_rem"}, remainder, er);
  endtask

  initial begin
    logic seen;
    rst       = 1'b1;
    start     = 1'b0;
    flush     = 1'b0;
    is_signed = 1'b0;
    dividend  = '0;
    divisor   = '0;
    cyc();
    cyc();
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_quo", quotient, 32'd0);
    chk("rst_rem", remainder, 32'd0);
    rst = 1'b0;
    cyc();

    launch(1'b0, 32'd100, 32'd7);
    finish_op("divu_100_7", 32'd14, 32'd2);
    cyc();
    chk("done_one_cycle", {31'b0, done}, 32'd0);

    launch(1'b1, 32'hFFFF_FFF9, 32'd2);
    finish_op("div_m7_2", 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    launch(1'b1, 32'd7, 32'hFFFF_FFFE);
    finish_op("div_7_m2", 32'hFFFF_FFFD, 32'd1);
    launch(1'b0, 32'hFFFF_FFF9, 32'd2);
    finish_op("divu_fff9_2", 32'h7FFF_FFFC, 32'd1);

    launch(1'b0, 32'h1234_5678, 32'd0);
    finish_op("divu_by0", 32'hFFFF_FFFF, 32'h1234_5678);
    launch(1'b1, 32'hFFFF_FFFB, 32'd0);
    finish_op("div_m5_by0", 32'hFFFF_FFFF, 32'hFFFF_FFFB);

    launch(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    finish_op("div_ovf", 32'h8000_0000, 32'd0);
    launch(1'b0, 32'hFFFF_FFFF, 32'd1);
    finish_op("divu_max_1", 32'hFFFF_FFFF, 32'd0);

    // Flush in cycle 10; a start in cycle 5 must be ignored.
    launch(1'b0, 32'd50, 32'd5);
    repeat (4) cyc();
    launch(1'b0, 32'd9, 32'd4);
    repeat (4) cyc();
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    chk("flush_busy11", {31'b0, busy}, 32'd0);
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
      cyc();
    end
    chk("flush_no_done", {31'b0, seen}, 32'd0);
    chk("flush_quo_hold", quotient, 32'hFFFF_FFFF);
    chk("flush_rem_hold", remainder, 32'd0);

    // Flush together with start in IDLE: nothing starts.
    is_signed = 1'b0;
    dividend  = 32'd9;
    divisor   = 32'd4;
    start     = 1'b1;
    flush     = 1'b1;
    cyc();
    start = 1'b0;
    flush = 1'b0;
    chk("flush_start_idle", {31'b0, busy}, 32'd0);
    launch(1'b0, 32'd9, 32'd4);
    finish_op("divu_9_4", 32'd2, 32'd1);

    // Reset in cycle 20 of an operation.
    launch(1'b0, 32'd1000, 32'd3);
    repeat (19) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    chk("midrst_done", {31'b0, done}, 32'd0);
    chk("midrst_quo", quotient, 32'd0);
    chk("midrst_rem", remainder, 32'd0);
    launch(1'b0, 32'd1000, 32'd3);
    finish_op("after_rst", 32'd333, 32'd1);

    // Back-to-back: start in the done cycle.
    launch(1'b0, 32'd20, 32'd3);
    finish_op("b2b_first", 32'd6, 32'd2);
    launch(1'b0, 32'd100, 32'd9);
    chk("b2b_busy", {31'b0, busy}, 32'd1);
    chk("b2b_quo_hold", quotient, 32'd6);
    chk("b2b_rem_hold", remainder, 32'd2);
    finish_op("b2b_second", 32'd11, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
